// File: rtl/mult_share_pkg.sv
// mult_share_pkg: shared constants and FSM state type for the multiplier-sharing arbiter
package mult_share_pkg;
    localparam int NUM_REQ = 4;
    localparam int ID_W = 2;
    localparam int OP_W = 4;
    typedef enum logic [1:0] {IDLE, CALC, RESP} state_t;
endpackage

// File: rtl/array_mult_core_4bit.sv
// array_mult_core_4bit: combinational 4x4 unsigned array multiplier
module array_mult_core_4bit
    import mult_share_pkg::*;
(
    input  logic [OP_W-1:0]   A,
    input  logic [OP_W-1:0]   B,
    output logic [2*OP_W-1:0] OUT
);
    // Accumulate one shifted partial-product row per multiplier bit
    always_comb begin
        OUT = '0;
        for (int i = 0; i < OP_W; i++) OUT = OUT + ({{OP_W{1'b0}}, A & {OP_W{B[i]}}} << i);
    end
endmodule

// File: rtl/mult_share_arbiter.sv
// mult_share_arbiter: round-robin arbiter sharing one 4x4 multiplier; MULT_SHARE_ARBITER_STATS_EN builds op_count
module mult_share_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_REQ-1:0]   req_valid,
    output logic [NUM_REQ-1:0]   req_ready,
    input  logic [NUM_REQ*4-1:0] req_a,
    input  logic [NUM_REQ*4-1:0] req_b,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [ID_W-1:0]      rsp_id,
    output logic [7:0]           rsp_prod,
    output logic [15:0]          op_count
);
    import mult_share_pkg::*;
    state_t state, state_nxt;
    logic [ID_W-1:0] rr_ptr, gnt_idx;
    logic [OP_W-1:0] a_q, b_q;
    logic [7:0] prod;
    logic gnt;
    array_mult_core_4bit u_mult (.A(a_q), .B(b_q), .OUT(prod));
    // First valid requester at or above rr_ptr with wrap; lowest offset assigned last wins
    always_comb begin
        gnt_idx = rr_ptr;
        for (int i = NUM_REQ - 1; i >= 0; i--)
            if (req_valid[rr_ptr + ID_W'(i)]) gnt_idx = rr_ptr + ID_W'(i);
    end
    // Next state and grant decode; no grant is offered while reset is asserted
    always_comb begin
        state_nxt = state;
        req_ready = '0;
        gnt = 1'b0;
        case (state)
            IDLE: if (rst_n && |req_valid) begin
                gnt = 1'b1;
                req_ready[gnt_idx] = 1'b1;
                state_nxt = CALC;
            end
            CALC: state_nxt = RESP;
            RESP: state_nxt = rsp_ready ? IDLE : RESP;
            default: state_nxt = IDLE;
        endcase
    end
    // State register
    always_ff @(posedge clk) state <= !rst_n ? IDLE : state_nxt;
    // Operand capture on grant, product registration in CALC, response handshake in RESP
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rr_ptr <= '0;
            a_q <= '0;
            b_q <= '0;
            rsp_id <= '0;
            rsp_prod <= '0;
            rsp_valid <= 1'b0;
        end else begin
            if (gnt) begin
                rr_ptr <= gnt_idx + 1'b1;
                a_q <= req_a[gnt_idx*OP_W +: OP_W];
                b_q <= req_b[gnt_idx*OP_W +: OP_W];
                rsp_id <= gnt_idx;
            end
            if (state == CALC) begin
                rsp_prod <= prod;
                rsp_valid <= 1'b1;
            end else if (state == RESP && rsp_ready) begin
                rsp_valid <= 1'b0;
            end
        end
    end
`ifdef MULT_SHARE_ARBITER_STATS_EN
    // Completed-operation counter, saturating at all-ones
    always_ff @(posedge clk) begin
        if (!rst_n) op_count <= '0;
        else if (rsp_valid && rsp_ready && op_count != 16'hFFFF) op_count <= op_count + 16'd1;
    end
`else
    assign op_count = '0;
`endif
endmodule
